serial_pad_shifter: RTL and testbench

SERIAL_PAD_SHIFTER -- requirements
Module: serial_pad_shifter

---
 rtl/serial_pad_shifter.sv | 160 ++++++++++++++++
 tb/tb_serial_pad_shifter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pad_shifter.sv
`default_nettype none
// ============================================================================
// Module   : serial_pad_shifter
// Purpose  : Buffered multi-channel console-pad shifter; optional latch
//            counter output enabled by SERIAL_PAD_SHIFTER_LATCH_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pad_shifter #(
  parameter int WIDTH      = 16,
  parameter int NUM_CH     = 1,
  parameter int DEPTH      = 4,
  parameter int SHIFT_EDGE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      latch_in,
  input  logic                      pad_clk_in,
  input  logic                      overread,
  input  logic [WIDTH*NUM_CH-1:0]   frame_data,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  output logic [NUM_CH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]    level,
  output logic [$clog2(WIDTH):0]    bit_count,
`ifdef SERIAL_PAD_SHIFTER_LATCH_COUNT_EN
  output logic [15:0]               latch_count,
`endif
  output logic                      underflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(WIDTH);
  localparam int c_FW = WIDTH * NUM_CH;

  logic [2:0]          r_latch_sync;
  logic [2:0]          r_pclk_sync;
  logic [c_FW-1:0]     r_mem [DEPTH];
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_AW:0]       r_level;
  logic [c_FW-1:0]     r_shift;
  logic [NUM_CH-1:0]   r_data_out;
  logic [c_CW:0]       r_bit_count;
  logic                r_underflow;

  logic                w_latch_rise;
  logic                w_pclk_edge;
  logic                w_shift;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [c_FW-1:0]     w_load_data;
  logic [c_FW-1:0]     w_shifted;
  logic [NUM_CH-1:0]   w_load_msb;
  logic [NUM_CH-1:0]   w_shift_msb;
  logic                w_last_bit;

  // Stage [1] is the synchronized level, stage [2] the history for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latch_sync <= '0;
      r_pclk_sync  <= '0;
    end else begin
      r_latch_sync <= {r_latch_sync[1:0], latch_in};
      r_pclk_sync  <= {r_pclk_sync[1:0], pad_clk_in};
    end
  end

  assign w_latch_rise = r_latch_sync[1] & ~r_latch_sync[2];
  assign w_pclk_edge  = (SHIFT_EDGE == 0) ? (r_pclk_sync[1] & ~r_pclk_sync[2])
                                          : (~r_pclk_sync[1] & r_pclk_sync[2]);
  // Latch high (including its rising-edge cycle) suppresses any shift.
  assign w_shift      = w_pclk_edge & ~r_latch_sync[1];

  assign w_empty      = (r_level == '0);
  assign w_full       = (r_level == (c_AW+1)'(DEPTH));
  assign w_push       = frame_valid & ~w_full;
  assign w_pop        = w_latch_rise & ~w_empty;
  assign w_load_data  = w_empty ? {c_FW{1'b1}} : r_mem[r_rd_ptr];
  assign w_last_bit   = (r_bit_count >= (c_CW+1)'(WIDTH - 1));

  always_comb begin
    w_shifted   = '0;
    w_load_msb  = '0;
    w_shift_msb = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_shifted[c*WIDTH +: WIDTH] = {r_shift[c*WIDTH +: WIDTH-1], overread};
      w_shift_msb[c]              = r_shift[c*WIDTH + WIDTH - 2];
      w_load_msb[c]               = w_load_data[c*WIDTH + WIDTH - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= frame_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Once a frame is exhausted the output follows the live overread value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '1;
      r_data_out  <= '1;
      r_bit_count <= (c_CW+1)'(WIDTH);
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_latch_rise & w_empty;
      if (w_latch_rise) begin
        r_shift     <= w_load_data;
        r_data_out  <= w_load_msb;
        r_bit_count <= '0;
      end else if (w_shift) begin
        r_shift    <= w_shifted;
        r_data_out <= w_last_bit ? {NUM_CH{overread}} : w_shift_msb;
        if (r_bit_count != (c_CW+1)'(WIDTH)) begin
          r_bit_count <= r_bit_count + 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_PAD_SHIFTER_LATCH_COUNT_EN
  logic [15:0] r_latch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latch_count <= '0;
    end else if (w_latch_rise) begin
      r_latch_count <= r_latch_count + 16'd1;
    end
  end

  assign latch_count = r_latch_count;
`endif

  assign frame_ready = ~w_full;
  assign data_out    = r_data_out;
  assign level       = r_level;
  assign bit_count   = r_bit_count;
  assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_pad_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pad_shifter
// Purpose  : Randomized self-checking bench against a frame-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pad_shifter;

  localparam int c_W  = 8;
  localparam int c_CH = 2;
  localparam int c_D  = 4;
  localparam int c_FW = c_W * c_CH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              latch_in;
  logic              pad_clk_in;
  logic              overread;
  logic [c_FW-1:0]   frame_data;
  logic              frame_valid;
  logic              frame_ready;
  logic [c_CH-1:0]   data_out;
  logic [2:0]        level;
  logic [3:0]        bit_count;
  logic              underflow;
`ifdef SERIAL_PAD_SHIFTER_LATCH_COUNT_EN
  logic [15:0]       latch_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of pending frames plus the frame currently on the wire.
  logic [c_FW-1:0]   q[$];
  logic [c_FW-1:0]   cur;
  int                k;
  logic              ovr;
  int                n_latch;

  serial_pad_shifter #(
    .WIDTH(c_W), .NUM_CH(c_CH), .DEPTH(c_D), .SHIFT_EDGE(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .latch_in(latch_in), .pad_clk_in(pad_clk_in),
    .overread(overread), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .data_out(data_out), .level(level),
    .bit_count(bit_count),
`ifdef SERIAL_PAD_SHIFTER_LATCH_COUNT_EN
    .latch_count(latch_count),
`endif
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    logic [c_CH-1:0] e;
    for (int c = 0; c < c_CH; c++) begin
      e[c] = (k < c_W) ? cur[c*c_W + c_W - 1 - k] : ovr;
    end
    check_val({tag, "_dout"}, 64'(data_out), 64'(e));
    check_val({tag, "_bcnt"}, 64'(bit_count), 64'((k > c_W) ? c_W : k));
    check_val({tag, "_lvl"},  64'(level), 64'(q.size()));
    check_val({tag, "_rdy"},  64'(frame_ready), 64'(q.size() < c_D));
  endtask

  task automatic write_frame(input logic [c_FW-1:0] d);
    @(negedge clk);
    frame_data  = d;
    frame_valid = 1'b1;
    check_val("wr_rdy", 64'(frame_ready), 64'(q.size() < c_D));
    @(posedge clk);
    if (q.size() < c_D) q.push_back(d);
    #1;
    check_val("wr_lvl", 64'(level), 64'(q.size()));
  endtask

  task automatic end_write();
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic do_latch(input bit with_write, input logic [c_FW-1:0] d);
    bit exp_uf;
    bit accept;
    accept = 1'b0;
    @(negedge clk);
    latch_in = 1'b1;
    repeat (2) @(posedge clk);
    if (with_write) begin
      @(negedge clk);
      frame_data  = d;
      frame_valid = 1'b1;
      accept      = (q.size() < c_D);
    end
    @(posedge clk);
    exp_uf = (q.size() == 0);
    cur    = exp_uf ? '1 : q.pop_front();
    k      = 0;
    if (accept) q.push_back(d);
    n_latch++;
    #1;
    check_out("latch");
    check_val("uf_pulse", 64'(underflow), 64'(exp_uf));
`ifdef SERIAL_PAD_SHIFTER_LATCH_COUNT_EN
    check_val("lcnt", 64'(latch_count), 64'(n_latch & 16'hFFFF));
`endif
    @(negedge clk);
    frame_valid = 1'b0;
    pad_clk_in  = 1'b1;
    @(posedge clk);
    #1;
    check_val("uf_end", 64'(underflow), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check_out("latch_hold");
    @(negedge clk);
    pad_clk_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    latch_in = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_shift(input logic o);
    @(negedge clk);
    overread   = o;
    pad_clk_in = 1'b1;
    repeat (3) @(posedge clk);
    k++;
    ovr = o;
    #1;
    check_out("shift");
    @(negedge clk);
    pad_clk_in = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    latch_in    = 1'b0;
    pad_clk_in  = 1'b0;
    frame_valid = 1'b0;
    #1;
    q.delete();
    cur     = '1;
    k       = c_W;
    ovr     = 1'b1;
    n_latch = 0;
    check_out("rst");
    check_val("rst_uf", 64'(underflow), 64'd0);
`ifdef SERIAL_PAD_SHIFTER_LATCH_COUNT_EN
    check_val("rst_lcnt", 64'(latch_count), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_n       = 1'b1;
    latch_in    = 1'b0;
    pad_clk_in  = 1'b0;
    overread    = 1'b0;
    frame_data  = '0;
    frame_valid = 1'b0;
    cur         = '1;
    k           = c_W;
    ovr         = 1'b1;
    n_latch     = 0;
    #2;
    apply_reset();

    // Known pattern: ch0 = 0xA5, ch1 = 0x3C, then exhaust with overread 0.
    write_frame(16'h3CA5);
    end_write();
    do_latch(1'b0, '0);
    for (int i = 0; i < c_W + 1; i++) do_shift(1'b0);

    // Empty-buffer latch, drained with overread 1.
    do_latch(1'b0, '0);
    for (int i = 0; i < 10; i++) do_shift(1'b1);

    // Five back-to-back writes into a four-deep buffer.
    for (int i = 0; i < 5; i++) write_frame(16'h1111 * (i + 1));
    end_write();
    do_latch(1'b0, '0);
    write_frame(16'hBEEF);
    end_write();
    do_latch(1'b1, 16'hDEAD);
    do_latch(1'b0, '0);
    do_latch(1'b1, 16'hC0DE);
    for (int i = 0; i < 3; i++) do_latch(1'b0, '0);

    // Complementary channels shifting together.
    write_frame(16'h00FF);
    end_write();
    do_latch(1'b0, '0);
    for (int i = 0; i < 4; i++) do_shift(1'b0);

    // Reset mid-frame with frames pending, then a latch must underflow.
    write_frame(16'h5A5A);
    write_frame(16'hA5A5);
    end_write();
    do_latch(1'b0, '0);
    write_frame(16'h1234);
    end_write();
    for (int i = 0; i < 5; i++) do_shift(1'b0);
    apply_reset();
    do_latch(1'b0, '0);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          write_frame(16'($urandom));
          end_write();
        end
        1: do_latch(1'($urandom_range(0, 1)), 16'($urandom));
        default: begin
          for (int s = 0; s < $urandom_range(1, 10); s++) do_shift(1'($urandom_range(0, 1)));
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
